// File: rtl/stream_demux.sv
// stream_demux: routes one valid/ready input stream to one of two output
// streams. Each output is buffered by its own DEPTH-entry FIFO, so
// backpressure on one output never stalls traffic bound for the other.
// Per-output 16-bit counters record how many words were accepted for it.
module stream_demux #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2    // power of two, >= 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
);

  // Pointers carry one extra wrap bit so that full and empty stay distinct
  // at every occupancy from 0 to DEPTH.
  localparam int PTR_W = $clog2(DEPTH);

  logic [1:0]             empty;
  logic [1:0]             full;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             out_ready;
  logic [1:0][DATA_W-1:0] head;
  logic [1:0][15:0]       cnt;

  assign out_ready = {out1_ready, out0_ready};

  // NOTE: in_ready looks only at the selected FIFO's full flag, never at a
  // same-cycle pop; this keeps the ready path short and avoids a
  // combinational loop through the downstream ready.
  assign in_ready = in_sel ? ~full[1] : ~full[0];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;

    assign empty[g] = (wr_ptr == rd_ptr);
    assign full[g]  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push[g]  = in_valid && in_ready && (in_sel == 1'(g));
    // A ready with nothing buffered is simply ignored.
    assign pop[g]   = ~empty[g] && out_ready[g];
    assign head[g]  = mem[rd_ptr[PTR_W-1:0]];

    // FIFO storage, pointers and accept counter for this output.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt[g] <= '0;
        // NOTE: storage is cleared too, so the head (and therefore outN_data)
        // reads zero during and right after reset rather than stale words.
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else begin
        if (push[g]) begin
          mem[wr_ptr[PTR_W-1:0]] <= in_data;
          wr_ptr                 <= wr_ptr + 1'b1;
          cnt[g]                 <= cnt[g] + 16'd1;
        end
        if (pop[g]) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  assign out0_valid = ~empty[0];
  assign out1_valid = ~empty[1];
  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: stimulus pushes expected words into a
// per-output queue on acceptance; a monitor pops and compares on each output
// transfer.
`timescale 1ns/1ps
module tb_stream_demux;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sel = 1'b0;
  logic              out0_valid, out1_valid;
  logic              out0_ready = 1'b0, out1_ready = 1'b0;
  logic [DATA_W-1:0] out0_data, out1_data;
  logic [15:0]       cnt0, cnt1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_pop0 = 0;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];

  stream_demux #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every output transfer against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid) begin
        if (q0.size() == 0) check("out0 unexpected valid", 1, 0);
        else if (out0_ready) begin
          check("out0 data", out0_data, q0.pop_front());
          last_pop0 = cyc + 1;
        end
      end
      if (out1_valid) begin
        if (q1.size() == 0) check("out1 unexpected valid", 1, 0);
        else if (out1_ready) check("out1 data", out1_data, q1.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) sync();
  endtask

  // Offers one word; returns (at edge+1ns) after it is accepted or on timeout.
  task automatic send(input logic sel, input logic [DATA_W-1:0] data, output int acc_edge);
    int waited = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    acc_edge = -1;
    while (acc_edge < 0) begin
      @(negedge clk);
      if (in_ready) begin
        if (sel) q1.push_back(data);
        else     q0.push_back(data);
        acc_edge = cyc + 1;
      end else if (waited >= 20) begin
        check("send timeout", 0, 1);
        break;
      end
      waited++;
      sync();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    wait_cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e;
    int first;

    // Reset state
    #3;
    check("reset in_ready", in_ready, 1);
    check("reset out0_valid", out0_valid, 0);
    check("reset out1_valid", out1_valid, 0);
    check("reset out0_data", out0_data, 0);
    check("reset out1_data", out1_data, 0);
    check("reset cnt0", cnt0, 0);
    check("reset cnt1", cnt1, 0);
    wait_cycles(2);
    rst_n = 1'b1;
    sync();

    // Route check, both outputs ready
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(1'b0, 32'hA5A5_0001, e);
    @(negedge clk);
    check("route out0_valid", out0_valid, 1);
    check("route out0_data", out0_data, 32'hA5A5_0001);
    check("route out1 idle", out1_valid, 0);
    sync();
    send(1'b1, 32'hA5A5_0002, e);
    @(negedge clk);
    check("route out1_valid", out1_valid, 1);
    check("route out1_data", out1_data, 32'hA5A5_0002);
    sync();
    @(negedge clk);
    check("route cnt0", cnt0, 1);
    check("route cnt1", cnt1, 1);
    sync();

    // Inputs ignored while in_valid=0
    in_sel  = 1'b1;
    in_data = 32'hDEAD_BEEF;
    wait_cycles(3);
    @(negedge clk);
    check("idle cnt0", cnt0, 1);
    check("idle cnt1", cnt1, 1);
    check("idle out1_valid", out1_valid, 0);
    sync();

    // Full boundary on out1
    out1_ready = 1'b0;
    send(1'b1, 32'h0000_0011, e);
    send(1'b1, 32'h0000_0012, e);
    in_valid = 1'b1;
    in_sel   = 1'b1;
    in_data  = 32'h0000_0013;
    repeat (3) begin
      @(negedge clk);
      check("full in_ready", in_ready, 0);
      check("full out1_valid", out1_valid, 1);
      check("full out1_data", out1_data, 32'h0000_0011);
      sync();
    end
    in_valid = 1'b0;
    check("full cnt1", cnt1, 3);

    // Independence: out0 keeps flowing while out1 is full
    send(1'b0, 32'h0000_0021, e);
    send(1'b0, 32'h0000_0022, e);
    send(1'b0, 32'h0000_0023, e);
    wait_cycles(3);
    @(negedge clk);
    check("indep cnt0", cnt0, 4);
    check("indep cnt1", cnt1, 3);
    check("indep out1_data", out1_data, 32'h0000_0011);
    check("indep out0 drained", q0.size(), 0);
    sync();
    out1_ready = 1'b1;
    wait_cycles(4);
    check("out1 drained", q1.size(), 0);

    // Streaming 100 words on out0
    do_reset();
    out0_ready = 1'b1;
    first = -1;
    for (int i = 0; i < 100; i++) begin
      send(1'b0, DATA_W'(i), e);
      if (i == 0) first = e;
    end
    wait_cycles(3);
    check("stream cnt0", cnt0, 100);
    check("stream drained", q0.size(), 0);
    check("stream span", last_pop0 - first, 100);

    // Mid-operation asynchronous reset
    out0_ready = 1'b0;
    send(1'b0, 32'h0000_0055, e);
    send(1'b0, 32'h0000_0066, e);
    @(negedge clk);
    check("pre-reset out0_valid", out0_valid, 1);
    check("pre-reset out0_data", out0_data, 32'h0000_0055);
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check("async out0_valid", out0_valid, 0);
    check("async out0_data", out0_data, 0);
    check("async cnt0", cnt0, 0);
    check("async in_ready", in_ready, 1);
    sync();
    rst_n = 1'b1;
    out0_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post-reset out0_valid", out0_valid, 0);
      check("post-reset cnt0", cnt0, 0);
      sync();
    end
    send(1'b0, 32'h0000_0077, e);
    wait_cycles(2);
    check("post-reset cnt0 after push", cnt0, 1);
    check("post-reset drained", q0.size(), 0);

    // Counter wrap: 65537 transfers
    do_reset();
    out0_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      send(1'b0, DATA_W'(i), e);
    end
    wait_cycles(3);
    check("wrap cnt0", cnt0, 16'h0001);
    check("wrap cnt1", cnt1, 0);
    check("wrap drained", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the per-output FIFO depth in entries; the value SHALL be a power of two and at least 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port in_valid: input, 1 bit, upstream word is present.
REQ-007 Port in_ready: output, 1 bit, the block accepts the upstream word.
REQ-008 Port in_data: input, DATA_W bits, upstream payload.
REQ-009 Port in_sel: input, 1 bit, destination select (0 routes to out0, 1 routes to out1).
REQ-010 Ports out0_valid (output, 1), out0_ready (input, 1) and out0_data (output, DATA_W) SHALL form the output-0 stream.
REQ-011 Ports out1_valid (output, 1), out1_ready (input, 1) and out1_data (output, DATA_W) SHALL form the output-1 stream.
REQ-012 Ports cnt0 and cnt1: outputs, 16 bits each, count of words accepted for output 0 and output 1 respectively.

Function
REQ-013 An input transfer SHALL occur on a rising clk edge when in_valid=1 and in_ready=1; the word SHALL be pushed into FIFO[in_sel].
REQ-014 in_ready SHALL be combinational and equal to NOT full(FIFO[in_sel]); it SHALL NOT depend on a same-cycle pop (no full-FIFO pass-through).
REQ-015 in_data and in_sel SHALL be sampled only at a transfer; values driven while in_valid=0 SHALL be ignored.
REQ-016 outN_valid SHALL equal NOT empty(FIFO[N]), and outN_data SHALL be the FIFO[N] head entry.
REQ-017 An output transfer (pop of FIFO[N]) SHALL occur on a rising edge when outN_valid=1 and outN_ready=1.
REQ-018 outN_data SHALL hold stable while outN_valid=1 and outN_ready=0.
REQ-019 Latency SHALL be exactly 1 cycle: a word accepted at edge k into an empty FIFO SHALL appear as valid after edge k; there SHALL be no combinational in-to-out bypass.
REQ-020 Word order SHALL be preserved within each output; no ordering SHALL be guaranteed between outputs.
REQ-021 A simultaneous push and pop on the same non-full, non-empty FIFO SHALL leave its occupancy unchanged and preserve order.
REQ-022 Backpressure on one output SHALL NOT block accepted traffic to the other output.
REQ-023 FIFO read and write pointers SHALL wrap modulo DEPTH, with the full and empty states distinguished at every occupancy from 0 to DEPTH.
REQ-024 cntN SHALL increment by 1 on each input transfer routed to N, SHALL wrap from 0xFFFF to 0x0000, and SHALL NOT change on pops.
REQ-025 outN_ready asserted while outN_valid=0 SHALL have no effect.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, clear both FIFOs, including pointers and storage.
REQ-027 During and after reset: out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0, and in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; no outN_valid SHALL assert after reset release until a new input transfer occurs.
REQ-029 rst_n deassertion is synchronised to clk externally; the block SHALL accept transfers from the first rising edge after release.

Verification
REQ-030 Route check: push 0xA5A5_0001 with sel=0, then 0xA5A5_0002 with sel=1, both outputs ready -> each word appears on its own output one cycle after acceptance; cnt0=1 and cnt1=1.
REQ-031 Full boundary: out1_ready=0, push 3 words with sel=1 at DEPTH=2 -> in_ready drops after the 2nd word; the 3rd word is held; out1_data stays at the first word.
REQ-032 Independence: continue the full-out1 case with sel=0 words -> all are accepted and drained on out0; out1 state is unchanged.
REQ-033 Streaming: continuous push and pop on out0 for 100 words of values 0..99 -> in-order delivery, 1 word per cycle after the first, and cnt0=100.
REQ-034 Counter wrap: 65537 transfers with sel=0 -> cnt0=0x0001.
REQ-035 Mid-operation reset: with out0 holding 2 words, pulse rst_n low asynchronously between edges -> outputs clear immediately; after release, valid stays 0 until the next push and the counters read 0.
